// File: rtl/sys_array_ctrl.sv
// sys_array_ctrl: job sequencer for a weight-stationary ROWS x COLS systolic MAC array.
// Loads weights row by row, streams skewed input vectors, drains, then pulses done.
module sys_array_ctrl #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vectors,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] y_base,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic [ROWS-1:0]   param_load_row,
    output logic              x_rd_en,
    output logic [ADDR_W-1:0] x_rd_addr,
    output logic [ROWS-1:0]   row_valid,
    output logic              y_wr_en,
    output logic [ADDR_W-1:0] y_wr_addr
);
    localparam int D  = ROWS + COLS;
    localparam int LW = ROWS > 1 ? $clog2(ROWS) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] COMPUTE = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]        state;
    logic [LW-1:0]     lcnt;
    logic [CNT_W-1:0]  vcnt, wcnt, n_q;
    logic [ADDR_W-1:0] w_base_q, x_base_q, y_base_q;
    logic [D-1:0]      xd;

    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign w_rd_en   = state == LOAD;
    assign x_rd_en   = state == COMPUTE;
    assign w_rd_addr = w_base_q + ADDR_W'(lcnt);
    assign x_rd_addr = x_base_q + ADDR_W'(vcnt);
    assign y_wr_addr = y_base_q + ADDR_W'(wcnt);
    // xd[k-1] is x_rd_en delayed k cycles: row r sees it after 1+r, the last column after ROWS+COLS
    assign row_valid = xd[ROWS-1:0];
    assign y_wr_en   = xd[D-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            lcnt           <= '0;
            vcnt           <= '0;
            wcnt           <= '0;
            n_q            <= '0;
            w_base_q       <= '0;
            x_base_q       <= '0;
            y_base_q       <= '0;
            xd             <= '0;
            param_load_row <= '0;
        end else begin
            xd             <= {xd[D-2:0], x_rd_en};
            param_load_row <= w_rd_en ? ROWS'(1) << lcnt : '0;
            if (y_wr_en) wcnt <= wcnt + 1'b1;
            case (state)
                IDLE: if (start) begin
                    n_q      <= num_vectors;
                    w_base_q <= w_base;
                    x_base_q <= x_base;
                    y_base_q <= y_base;
                    lcnt     <= '0;
                    vcnt     <= '0;
                    wcnt     <= '0;
                    state    <= num_vectors == '0 ? DONE : LOAD;
                end
                LOAD: begin
                    lcnt <= lcnt + 1'b1;
                    if (lcnt == LW'(ROWS - 1)) state <= COMPUTE;
                end
                COMPUTE: begin
                    vcnt <= vcnt + 1'b1;
                    if (vcnt == n_q - 1'b1) state <= DRAIN;
                end
                DRAIN: if (y_wr_en && wcnt == n_q - 1'b1) state <= DONE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
